// File: rtl/phase_diff_tracker.sv
// Pairs voltage/current FFT peak phases, emits the wrapped signed difference and a 2^AVG_LOG2 block average.
// Optional build macro PHASE_CAL_OFFSET_EN adds a cal_offset input that is subtracted from every difference.
module phase_diff_tracker #(
    parameter int PHASE_W  = 17,
    parameter int AVG_LOG2 = 3,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                done_v,
    input  logic [PHASE_W-1:0]  theta_v,
    input  logic                done_i,
    input  logic [PHASE_W-1:0]  theta_i,
`ifdef PHASE_CAL_OFFSET_EN
    input  logic [PHASE_W-1:0]  cal_offset,
`endif
    output logic [PHASE_W-1:0]  phase_diff,
    output logic                diff_valid,
    output logic [PHASE_W-1:0]  phase_avg,
    output logic                avg_valid,
    output logic                timeout_err,
    output logic [AVG_LOG2:0]   sample_cnt
);

    // state  | meaning
    // IDLE   | no sample held
    // WAIT_I | theta_v held, waiting for done_i
    // WAIT_V | theta_i held, waiting for done_v
    // PAIR   | both held; difference is registered on the edge leaving this state

    localparam int AW = PHASE_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BLOCK_LEN  = CW'(2 ** AVG_LOG2);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_V, PAIR} state_t;

    state_t                 state;
    logic [PHASE_W-1:0]     hold_v;
    logic [PHASE_W-1:0]     hold_i;
    logic [TW-1:0]          timer;
    logic signed [AW-1:0]   acc;

    logic [PHASE_W-1:0]     d;
    logic signed [AW-1:0]   d_ext;
    logic                   avg_due;
    logic signed [AW-1:0]   acc_base;
    logic [CW-1:0]          cnt_base;

    always_comb begin
`ifdef PHASE_CAL_OFFSET_EN
        d = hold_v - hold_i - cal_offset;
`else
        d = hold_v - hold_i;
`endif
        d_ext    = AW'($signed(d));
        avg_due  = (sample_cnt == BLOCK_LEN);
        // a finished block restarts from zero so a pair landing on the same edge is kept
        acc_base = avg_due ? '0 : acc;
        cnt_base = avg_due ? '0 : sample_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hold_v      <= '0;
            hold_i      <= '0;
            timer       <= '0;
            acc         <= '0;
            sample_cnt  <= '0;
            phase_diff  <= '0;
            diff_valid  <= 1'b0;
            phase_avg   <= '0;
            avg_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            diff_valid  <= 1'b0;
            avg_valid   <= 1'b0;
            timeout_err <= 1'b0;
            if (clr) begin
                state      <= IDLE;
                hold_v     <= '0;
                hold_i     <= '0;
                timer      <= '0;
                acc        <= '0;
                sample_cnt <= '0;
            end else begin
                if (avg_due) begin
                    phase_avg <= PHASE_W'(acc >>> AVG_LOG2);
                    avg_valid <= 1'b1;
                end
                if (state == PAIR) begin
                    phase_diff <= d;
                    diff_valid <= 1'b1;
                    acc        <= acc_base + d_ext;
                    sample_cnt <= cnt_base + CW'(1);
                end else begin
                    acc        <= acc_base;
                    sample_cnt <= cnt_base;
                end

                case (state)
                    IDLE, PAIR: begin
                        if (done_v && done_i) begin
                            hold_v <= theta_v;
                            hold_i <= theta_i;
                            state  <= PAIR;
                        end else if (done_v) begin
                            hold_v <= theta_v;
                            timer  <= TIMER_LOAD;
                            state  <= WAIT_I;
                        end else if (done_i) begin
                            hold_i <= theta_i;
                            timer  <= TIMER_LOAD;
                            state  <= WAIT_V;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                    WAIT_I: begin
                        if (done_i) begin
                            hold_i <= theta_i;
                            if (done_v) hold_v <= theta_v;
                            state  <= PAIR;
                        end else if (done_v) begin
                            hold_v <= theta_v;
                            timer  <= TIMER_LOAD;
                        end else if (timer == '0) begin
                            timeout_err <= 1'b1;
                            hold_v      <= '0;
                            state       <= IDLE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    WAIT_V: begin
                        if (done_v) begin
                            hold_v <= theta_v;
                            if (done_i) hold_i <= theta_i;
                            state  <= PAIR;
                        end else if (done_i) begin
                            hold_i <= theta_i;
                            timer  <= TIMER_LOAD;
                        end else if (timer == '0) begin
                            timeout_err <= 1'b1;
                            hold_i      <= '0;
                            state       <= IDLE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_diff_tracker.sv
// Directed bench for phase_diff_tracker (PHASE_W=17, AVG_LOG2=2, TIMEOUT=16) with hand-computed expectations.
module tb_phase_diff_tracker;

    localparam int PW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          done_v = 1'b0;
    logic [PW-1:0] theta_v = '0;
    logic          done_i = 1'b0;
    logic [PW-1:0] theta_i = '0;
`ifdef PHASE_CAL_OFFSET_EN
    logic [PW-1:0] cal_offset = '0;
`endif
    logic [PW-1:0] phase_diff;
    logic          diff_valid;
    logic [PW-1:0] phase_avg;
    logic          avg_valid;
    logic          timeout_err;
    logic [2:0]    sample_cnt;

    int tests = 0;
    int errors = 0;
    int n_diff = 0;
    int n_avg = 0;
    int n_to = 0;
    int snap_diff, snap_avg, snap_to;

    phase_diff_tracker #(.PHASE_W(PW), .AVG_LOG2(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .done_v(done_v), .theta_v(theta_v),
        .done_i(done_i), .theta_i(theta_i),
`ifdef PHASE_CAL_OFFSET_EN
        .cal_offset(cal_offset),
`endif
        .phase_diff(phase_diff), .diff_valid(diff_valid),
        .phase_avg(phase_avg), .avg_valid(avg_valid),
        .timeout_err(timeout_err), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (diff_valid)  n_diff++;
        if (avg_valid)   n_avg++;
        if (timeout_err) n_to++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // both strobes together; returns just after the edge that registers phase_diff
    task automatic do_pair(input logic [PW-1:0] tv, input logic [PW-1:0] ti);
        done_v = 1'b1; theta_v = tv;
        done_i = 1'b1; theta_i = ti;
        step();
        done_v = 1'b0; done_i = 1'b0;
        step();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_diff"},  32'(phase_diff), 0);
        check_eq({tag, "_dv"},    32'(diff_valid), 0);
        check_eq({tag, "_avg"},   32'(phase_avg), 0);
        check_eq({tag, "_av"},    32'(avg_valid), 0);
        check_eq({tag, "_to"},    32'(timeout_err), 0);
        check_eq({tag, "_cnt"},   32'(sample_cnt), 0);
    endtask

    initial begin
        step();
        step();
        check_all_zero("reset");
        rst = 1'b1;
        step();

        // basic pair: done_i three cycles after done_v
        done_v = 1'b1; theta_v = 17'd1000;
        step();
        done_v = 1'b0;
        step();
        step();
        done_i = 1'b1; theta_i = 17'd300;
        step();
        done_i = 1'b0;
        check_eq("basic_early", 32'(diff_valid), 0);
        step();
        check_eq("basic_dv", 32'(diff_valid), 1);
        check_eq("basic_diff", 32'(phase_diff), 700);
        check_eq("basic_cnt", 32'(sample_cnt), 1);
        step();
        check_eq("basic_dv_pulse", 32'(diff_valid), 0);

        // clr keeps outputs but drops the count
        do_clr();
        check_eq("clr_cnt", 32'(sample_cnt), 0);
        check_eq("clr_keep_diff", 32'(phase_diff), 700);

        // wrap-around with simultaneous strobes
        do_pair(17'd100, 17'd131000);
        check_eq("wrap_pos", 32'(phase_diff), 172);
        do_pair(17'd131000, 17'd100);
        check_eq("wrap_neg", 32'(phase_diff), 32'h1FF54);

        // positive block average
        do_clr();
        snap_avg = n_avg;
        do_pair(17'd1100, 17'd1000);
        do_pair(17'd1200, 17'd1000);
        do_pair(17'd1300, 17'd1000);
        do_pair(17'd1400, 17'd1000);
        check_eq("avg_cnt_full", 32'(sample_cnt), 4);
        check_eq("avg_not_yet", 32'(avg_valid), 0);
        step();
        check_eq("avg_valid", 32'(avg_valid), 1);
        check_eq("avg_pos", 32'(phase_avg), 250);
        check_eq("avg_cnt_clear", 32'(sample_cnt), 0);
        step();
        step();
        check_eq("avg_once", 32'(n_avg - snap_avg), 1);

        // negative block average rounds toward -inf
        do_pair(17'd0, 17'd1);
        check_eq("neg_diff", 32'(phase_diff), 32'h1FFFF);
        do_pair(17'd10, 17'd12);
        do_pair(17'd10, 17'd12);
        do_pair(17'd10, 17'd12);
        step();
        check_eq("avg_neg", 32'(phase_avg), 32'h1FFFE);

        // timeout on missing partner
        do_clr();
        snap_diff = n_diff;
        snap_to = n_to;
        done_v = 1'b1; theta_v = 17'd777;
        step();
        done_v = 1'b0;
        repeat (15) step();
        check_eq("to_early", 32'(timeout_err), 0);
        step();
        check_eq("to_pulse", 32'(timeout_err), 1);
        step();
        check_eq("to_once", 32'(n_to - snap_to), 1);
        check_eq("to_no_diff", 32'(n_diff - snap_diff), 0);
        do_pair(17'd5000, 17'd4000);
        check_eq("to_after_diff", 32'(phase_diff), 1000);
        check_eq("to_after_cnt", 32'(sample_cnt), 1);

        // latest value of the held channel wins
        do_clr();
        snap_diff = n_diff;
        done_v = 1'b1; theta_v = 17'd500;
        step();
        done_v = 1'b0;
        step();
        done_v = 1'b1; theta_v = 17'd900;
        step();
        done_v = 1'b0;
        step();
        done_i = 1'b1; theta_i = 17'd100;
        step();
        done_i = 1'b0;
        step();
        check_eq("ovr_diff", 32'(phase_diff), 800);
        step();
        check_eq("ovr_once", 32'(n_diff - snap_diff), 1);

        // clr while in PAIR drops the pair and its pulse
        done_v = 1'b1; theta_v = 17'd60; done_i = 1'b1; theta_i = 17'd50;
        step();
        done_v = 1'b0; done_i = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("clr_pair_dv", 32'(diff_valid), 0);
        check_eq("clr_pair_keep", 32'(phase_diff), 800);

        // reset mid-block
        do_pair(17'd177, 17'd100);
        do_pair(17'd177, 17'd100);
        do_pair(17'd177, 17'd100);
        check_eq("mid_cnt", 32'(sample_cnt), 3);
        rst = 1'b0;
        step();
        check_all_zero("rst_mid1");
        step();
        check_all_zero("rst_mid2");
        rst = 1'b1;
        step();
        repeat (4) do_pair(17'd140, 17'd100);
        step();
        check_eq("rst_avg_v", 32'(avg_valid), 1);
        check_eq("rst_avg", 32'(phase_avg), 40);

        // clr mid-block
        do_pair(17'd177, 17'd100);
        do_pair(17'd177, 17'd100);
        do_pair(17'd177, 17'd100);
        do_clr();
        check_eq("clrmid_cnt", 32'(sample_cnt), 0);
        check_eq("clrmid_keep", 32'(phase_diff), 77);
        repeat (4) do_pair(17'd140, 17'd100);
        step();
        check_eq("clrmid_avg", 32'(phase_avg), 40);

        // back-to-back pairs across a block boundary: fifth pair lands on the average edge
        do_clr();
        done_v = 1'b1; theta_v = 17'd1140; done_i = 1'b1; theta_i = 17'd1100;
        repeat (5) step();
        done_v = 1'b0; done_i = 1'b0;
        check_eq("stream_cnt4", 32'(sample_cnt), 4);
        step();
        check_eq("stream_av", 32'(avg_valid), 1);
        check_eq("stream_avg", 32'(phase_avg), 40);
        check_eq("stream_cnt1", 32'(sample_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
